// File: rtl/ym_wr_seq_if.sv
// Host request channel and jt03 CPU bus, bundled for the YM register-write sequencer.
// The slave side is the sequencer. The master side is the host/ROM player plus the jt03 core.
interface ym_wr_seq_if;
    // Host write request
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_reg;
    logic [7:0] req_data;
    // jt03 CPU bus
    logic       ym_cs_n;
    logic       ym_wr_n;
    logic       ym_addr;
    logic [7:0] ym_din;
    logic [7:0] ym_dout;

    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_data,
        input  ym_dout,
        output req_ready,
        output ym_cs_n,
        output ym_wr_n,
        output ym_addr,
        output ym_din
    );

    modport master (
        output req_valid,
        output req_reg,
        output req_data,
        output ym_dout,
        input  req_ready,
        input  ym_cs_n,
        input  ym_wr_n,
        input  ym_addr,
        input  ym_din
    );
endinterface

// File: rtl/ym_wr_seq.sv
// YM2203 (jt03) register-write sequencer.
// Buffers {register, data} pairs in a FIFO. Each pair is replayed as an address-port
// write followed by a data-port write. The sequencer then polls the busy flag in dout[7]
// until it clears or a timeout expires. All outputs are registered. The strobes follow
// the FSM state by one cycle, so addr/din always lead cs_n/wr_n by a cycle.
module ym_wr_seq #(
    parameter int FIFO_AW     = 4,
    parameter int STROBE_CYC  = 4,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    ym_wr_seq_if.slave           bus,
    input  logic                 clr_err,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 idle,
    output logic                 timeout_err
);

    localparam int               DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [3:0]       STB_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYC - 1);
    localparam logic [9:0]       TO_LAST  = 10'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_STB,
        S_A_GAP,
        S_D_STB,
        S_D_GAP,
        S_POLL
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;

    // FIFO storage and bookkeeping
    logic [15:0]          r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic [FIFO_AW:0]     w_count_nx;
    logic                 r_ready;
    logic                 w_push;
    logic                 w_pop;
    logic [15:0]          w_head;

    // Sequencing
    logic [7:0]           r_data_q;
    logic [3:0]           r_cyc;
    logic [9:0]           r_poll_cnt;
    logic                 w_load_data;
    logic                 w_timeout;
    logic                 w_busy;
    logic [6:0]           w_unused_dout;

    // Registered outputs
    logic                 r_cs_n;
    logic                 r_wr_n;
    logic                 r_addr;
    logic [7:0]           r_din;
    logic                 r_idle;
    logic                 r_timeout_err;

    assign w_busy        = bus.ym_dout[7];
    assign w_unused_dout = bus.ym_dout[6:0];
    assign w_push        = bus.req_valid && r_ready;
    assign w_head        = r_mem[r_rd_ptr];

    // Next FIFO occupancy: a push and a pop in the same cycle cancel out
    always_comb begin
        w_count_nx = r_count;
        if (w_push && !w_pop) begin
            w_count_nx = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nx = r_count - 1'b1;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nx;
            r_ready <= (w_count_nx != FULL_CNT);
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.req_reg, bus.req_data};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state plus the pop, data-load and timeout strobes
    always_comb begin
        w_state_nx  = r_state;
        w_pop       = 1'b0;
        w_load_data = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_A_STB;
                end
            end
            S_A_STB: begin
                if (r_cyc == STB_LAST) begin
                    w_state_nx = S_A_GAP;
                end
            end
            S_A_GAP: begin
                if (r_cyc == GAP_LAST) begin
                    w_load_data = 1'b1;
                    w_state_nx  = S_D_STB;
                end
            end
            S_D_STB: begin
                if (r_cyc == STB_LAST) begin
                    w_state_nx = S_D_GAP;
                end
            end
            S_D_GAP: begin
                if (r_cyc == GAP_LAST) begin
                    w_state_nx = S_POLL;
                end
            end
            S_POLL: begin
                if (!w_busy) begin
                    w_state_nx = S_IDLE;
                end else if (r_poll_cnt == TO_LAST) begin
                    w_timeout  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Strobe/gap phase counter, restarted on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc <= '0;
        end else if ((w_state_nx != r_state) || (r_state == S_IDLE) || (r_state == S_POLL)) begin
            r_cyc <= '0;
        end else begin
            r_cyc <= r_cyc + 1'b1;
        end
    end

    // Busy-poll counter: zero outside POLL, counts busy cycles while polling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_poll_cnt <= '0;
        end else if ((r_state == S_POLL) && (w_state_nx == S_POLL)) begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
        end else begin
            r_poll_cnt <= '0;
        end
    end

    // Data byte of the popped pair, parked until the data-port write
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_data_q <= w_head[7:0];
        end
    end

    // jt03 bus drive: strobes lag the state by one cycle, addr/din change with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_n <= 1'b1;
            r_wr_n <= 1'b1;
            r_addr <= 1'b0;
            r_din  <= '0;
        end else begin
            r_cs_n <= !((r_state == S_A_STB) || (r_state == S_D_STB));
            r_wr_n <= !((r_state == S_A_STB) || (r_state == S_D_STB));
            if (w_pop) begin
                r_addr <= 1'b0;
                r_din  <= w_head[15:8];
            end else if (w_load_data) begin
                r_addr <= 1'b1;
                r_din  <= r_data_q;
            end
        end
    end

    // Status: idle flag and sticky timeout error (a new timeout beats clr_err)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle        <= 1'b1;
            r_timeout_err <= 1'b0;
        end else begin
            r_idle <= (r_count == '0) && (r_state == S_IDLE);
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (clr_err) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.ym_cs_n   = r_cs_n;
    assign bus.ym_wr_n   = r_wr_n;
    assign bus.ym_addr   = r_addr;
    assign bus.ym_din    = r_din;
    assign fifo_count    = r_count;
    assign idle          = r_idle;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_ym_wr_seq.sv
// Testbench for ym_wr_seq: directed scenarios with literal timing checks, plus a
// transaction-level model that predicts every output on every cycle.
module tb_ym_wr_seq;

    localparam int S = 4;
    localparam int G = 4;
    localparam int T = 1023;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_err;
    logic [4:0] fifo_count;
    logic       idle;
    logic       timeout_err;

    ym_wr_seq_if bus();

    ym_wr_seq #(
        .FIFO_AW    (4),
        .STROBE_CYC (S),
        .GAP_CYC    (G),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_err    (clr_err),
        .fifo_count (fifo_count),
        .idle       (idle),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- Transaction-level reference model ----------------
    // A write started by a pop is tracked by its cycle offset d (d=0 right after the pop):
    // strobes are low for d in [1,S] and [S+G+1,2S+G]; the data port is selected from
    // d=S+G; busy is sampled from d=2S+2G until clear or T polled cycles have passed.
    bit [15:0] m_q[$];
    bit        m_ok  = 1'b0;
    bit        m_act = 1'b0;
    int        m_d   = 0;
    bit [7:0]  m_reg;
    bit [7:0]  m_dat;
    bit        m_pop, m_push, m_done, m_tmo;
    logic       e_cs, e_addr, e_idle, e_rdy, e_err;
    logic [7:0] e_din;
    int         e_cnt;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_act  = 1'b0;
            m_d    = 0;
            e_cs   = 1'b1;
            e_addr = 1'b0;
            e_din  = 8'h00;
            e_idle = 1'b1;
            e_err  = 1'b0;
            m_ok   = 1'b1;
        end else begin
            m_pop  = !m_act && (m_q.size() != 0);
            m_push = bus.req_valid && (m_q.size() != D);
            m_done = 1'b0;
            m_tmo  = 1'b0;
            if (m_act && m_d >= 2*S + 2*G) begin
                if (!bus.ym_dout[7]) begin
                    m_done = 1'b1;
                end else if (m_d - (2*S + 2*G) == T - 1) begin
                    m_done = 1'b1;
                    m_tmo  = 1'b1;
                end
            end
            e_idle = (m_q.size() == 0) && !m_act;
            if (m_tmo) e_err = 1'b1;
            else if (clr_err) e_err = 1'b0;
            if (m_pop) begin
                {m_reg, m_dat} = m_q.pop_front();
                m_act = 1'b1;
                m_d   = 0;
            end else if (m_done) begin
                m_act = 1'b0;
            end else if (m_act) begin
                m_d++;
            end
            if (m_push) m_q.push_back({bus.req_reg, bus.req_data});
            e_cs = !(m_act && ((m_d >= 1 && m_d <= S) || (m_d >= S+G+1 && m_d <= 2*S+G)));
            if (m_act) begin
                e_addr = (m_d >= S + G);
                e_din  = e_addr ? m_dat : m_reg;
            end
        end
        e_cnt = m_q.size();
        e_rdy = (m_q.size() != D);
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            chk("cs_n",        32'(bus.ym_cs_n),   32'(e_cs));
            chk("wr_n",        32'(bus.ym_wr_n),   32'(e_cs));
            chk("addr",        32'(bus.ym_addr),   32'(e_addr));
            chk("din",         32'(bus.ym_din),    32'(e_din));
            chk("fifo_count",  32'(fifo_count),    32'(e_cnt));
            chk("req_ready",   32'(bus.req_ready), 32'(e_rdy));
            chk("idle",        32'(idle),          32'(e_idle));
            chk("timeout_err", 32'(timeout_err),   32'(e_err));
        end
    end

    // Strobe-start capture used for the FIFO replay-order check
    bit        cap_en  = 1'b0;
    bit        prev_cs = 1'b1;
    bit [8:0]  cap[$];

    initial forever begin
        @(negedge clk);
        if (cap_en && !bus.ym_cs_n && prev_cs) cap.push_back({bus.ym_addr, bus.ym_din});
        prev_cs = bus.ym_cs_n;
    end

    // Hard time bound for the whole run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (n_fail=%0d)", n_fail);
        $fatal(1, "time limit");
    end

    // Caller is at a negedge; the pair is accepted at the next posedge and the task
    // returns at the negedge right after it (offset k=0).
    task automatic push1(input logic [7:0] r, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_reg   = r;
        bus.req_data  = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (idle) break;
            @(negedge clk);
        end
        chk("wait_idle", 32'(idle), 32'd1);
    endtask

    int idx;
    bit flag;

    initial begin
        rst           = 1'b1;
        clr_err       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_reg   = 8'h00;
        bus.req_data  = 8'h00;
        bus.ym_dout   = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cs_n",  32'(bus.ym_cs_n),   32'd1);
        chk("rst_wr_n",  32'(bus.ym_wr_n),   32'd1);
        chk("rst_addr",  32'(bus.ym_addr),   32'd0);
        chk("rst_din",   32'(bus.ym_din),    32'd0);
        chk("rst_count", 32'(fifo_count),    32'd0);
        chk("rst_idle",  32'(idle),          32'd1);
        chk("rst_err",   32'(timeout_err),   32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single write, busy never set
        push1(8'h27, 8'h15);
        chk("sw_count_k0", 32'(fifo_count), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("sw_cs_n", 32'(bus.ym_cs_n), 32'(((k >= 2 && k <= 5) || (k >= 10 && k <= 13)) ? 0 : 1));
            if (k == 1)  chk("sw_count_k1", 32'(fifo_count), 32'd0);
            if (k == 2)  begin chk("sw_a_addr", 32'(bus.ym_addr), 32'd0); chk("sw_a_din", 32'(bus.ym_din), 32'h27); end
            if (k == 10) begin chk("sw_d_addr", 32'(bus.ym_addr), 32'd1); chk("sw_d_din", 32'(bus.ym_din), 32'h15); end
            if (k == 18) chk("sw_idle_k18", 32'(idle), 32'd0);
            if (k == 19) chk("sw_idle_k19", 32'(idle), 32'd1);
            if (k == 20) chk("sw_hold_din", 32'(bus.ym_din), 32'h15);
        end

        // Busy held for 30 cycles after the data strobe, a second write queued meanwhile
        push1(8'h28, 8'hAA);
        flag = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k >= 14 && k <= 45 && !bus.ym_cs_n) flag = 1'b1;
            if (k == 45) begin
                chk("busy_no_strobe", 32'(flag), 32'd0);
                chk("busy_err", 32'(timeout_err), 32'd0);
            end
            if (k == 46) chk("busy_next_strobe", 32'(bus.ym_cs_n), 32'd0);
            if (k == 13) bus.ym_dout = 8'h80;
            if (k == 43) bus.ym_dout = 8'h00;
            if (k == 20) begin bus.req_valid = 1'b1; bus.req_reg = 8'h29; bus.req_data = 8'h55; end
            if (k == 21) bus.req_valid = 1'b0;
        end
        wait_idle(100);

        // Busy stuck: timeout, clr_err colliding with the timeout, next write proceeds
        bus.ym_dout = 8'h80;
        push1(8'h2B, 8'h01);
        for (int k = 1; k <= 1050; k++) begin
            @(negedge clk);
            if (k == 5) begin bus.req_valid = 1'b1; bus.req_reg = 8'h2C; bus.req_data = 8'h02; end
            if (k == 6) bus.req_valid = 1'b0;
            if (k == 1039) begin chk("to_err_before", 32'(timeout_err), 32'd0); clr_err = 1'b1; end
            if (k == 1040) begin
                chk("to_err_set_wins", 32'(timeout_err), 32'd1);
                clr_err     = 1'b0;
                bus.ym_dout = 8'h00;
            end
            if (k == 1041) chk("to_next_cs_hi", 32'(bus.ym_cs_n), 32'd1);
            if (k == 1042) begin
                chk("to_next_cs_lo", 32'(bus.ym_cs_n), 32'd0);
                chk("to_next_din", 32'(bus.ym_din), 32'h2C);
            end
            if (k == 1045) clr_err = 1'b1;
            if (k == 1046) begin chk("clr_err", 32'(timeout_err), 32'd0); clr_err = 1'b0; end
        end
        wait_idle(100);

        // FIFO full: keep offering requests while busy holds the first write in POLL
        bus.ym_dout = 8'h80;
        idx = 0;
        repeat (20) begin
            bus.req_valid = 1'b1;
            bus.req_reg   = 8'(8'h30 + idx);
            bus.req_data  = 8'(8'hC0 + idx);
            if (bus.req_ready) idx++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("full_accepted", 32'(idx), 32'd17);
        chk("full_count", 32'(fifo_count), 32'd16);
        chk("full_ready", 32'(bus.req_ready), 32'd0);
        cap.delete();
        cap_en = 1'b1;
        bus.ym_dout = 8'h00;
        @(negedge clk);
        wait_idle(500);
        cap_en = 1'b0;
        chk("replay_strobes", 32'(cap.size()), 32'd32);
        for (int i = 0; i < 16 && (2*i + 1) < cap.size(); i++) begin
            chk("replay_reg",  32'(cap[2*i]),     32'({1'b0, 8'(8'h31 + i)}));
            chk("replay_data", 32'(cap[2*i + 1]), 32'({1'b1, 8'(8'hC1 + i)}));
        end

        // Simultaneous push and pop with one entry queued
        bus.req_valid = 1'b1;
        bus.req_reg   = 8'h40;
        bus.req_data  = 8'h11;
        @(negedge clk);
        chk("pp_count_k0", 32'(fifo_count), 32'd1);
        bus.req_reg  = 8'h41;
        bus.req_data = 8'h12;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pp_count_k1", 32'(fifo_count), 32'd1);
        wait_idle(100);

        // Reset in the middle of the data strobe with another entry queued
        push1(8'h50, 8'h33);
        bus.req_valid = 1'b1;
        bus.req_reg   = 8'h51;
        bus.req_data  = 8'h34;
        flag = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (k == 11) begin chk("rs_in_dstb", 32'(bus.ym_cs_n), 32'd0); rst = 1'b1; end
            if (k == 12) begin
                chk("rs_cs_n",  32'(bus.ym_cs_n), 32'd1);
                chk("rs_wr_n",  32'(bus.ym_wr_n), 32'd1);
                chk("rs_count", 32'(fifo_count),  32'd0);
                chk("rs_idle",  32'(idle),        32'd1);
                rst = 1'b0;
            end
            if (k > 12 && !bus.ym_cs_n) flag = 1'b1;
        end
        chk("rs_no_strobes", 32'(flag), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ym_wr_seq.md
Name: ym_wr_seq

Overview:
- Register-write sequencer directly upstream of the jt03 (YM2203) core.
- Queues {register, data} pairs from a host or ROM player in a FIFO and replays each one as an address write followed by a data write on the jt03 bus (cs_n/wr_n/addr/din).
- After each data write it waits for the jt03 busy flag (dout[7]) to clear, so the host never has to meet YM timing itself.

Parameters:
- FIFO_AW, 4: log2 of FIFO depth; depth = 2**FIFO_AW = 16 entries.
- STROBE_CYC, 4: clk cycles that cs_n/wr_n are held low per bus write; legal range 1..15.
- GAP_CYC, 4: clk cycles after each strobe with cs_n/wr_n high and addr/din held stable; legal range 1..15.
- TIMEOUT_CYC, 1023: maximum clk cycles spent polling busy before abandoning; legal range 1..1023.

Ports:
- clk  in  1  system clock, same clock as jt03.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  host presents a write request.
- req_ready  out  1  FIFO can accept; high when not full.
- req_reg  in  8  YM register number.
- req_data  in  8  value to write.
- ym_cs_n  out  1  to jt03 cs_n.
- ym_wr_n  out  1  to jt03 wr_n.
- ym_addr  out  1  to jt03 addr (0 = address port, 1 = data port).
- ym_din  out  8  to jt03 din.
- ym_dout  in  8  from jt03 dout; bit 7 = busy.
- fifo_count  out  FIFO_AW+1  current number of FIFO entries.
- idle  out  1  FIFO empty and FSM in IDLE.
- timeout_err  out  1  sticky; set when a busy poll times out.
- clr_err  in  1  clears timeout_err.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: ym_cs_n=1, ym_wr_n=1, ym_addr=0, ym_din=0, fifo_count=0, idle=1, timeout_err=0, req_ready=1, FSM=IDLE, FIFO pointers=0.
- Reset mid-operation: the FIFO is flushed, and cs_n/wr_n are high on the cycle after the reset edge. There is no partial completion.
- FIFO:
  - A push occurs when req_valid&req_ready; req_ready = (fifo_count != 2**FIFO_AW).
  - A pop occurs only in IDLE when the FIFO is non-empty.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - When full, req_ready is low and req_valid is ignored.
  - Pointers wrap modulo depth.
- FSM states: IDLE, A_STB, A_GAP, D_STB, D_GAP, POLL.
  - IDLE: if the FIFO is non-empty, pop into {reg_q, data_q} and go to A_STB. ym_addr=0 and ym_din=reg_q take effect on the same edge.
  - A_STB: cs_n=0, wr_n=0, addr=0, din=reg_q for STROBE_CYC cycles, then A_GAP.
  - A_GAP: cs_n=1, wr_n=1, addr/din held for GAP_CYC cycles, then D_STB. ym_addr=1 and ym_din=data_q take effect on the same edge.
  - D_STB: cs_n=0, wr_n=0, addr=1, din=data_q for STROBE_CYC cycles, then D_GAP.
  - D_GAP: strobes high, addr/din held for GAP_CYC cycles, then POLL.
  - POLL: sample ym_dout[7] each cycle.
    - If it is 0, go to IDLE on the next edge.
    - If a 10-bit counter reaches TIMEOUT_CYC while busy is still 1, set timeout_err and go to IDLE. The write is not retried.
    - The counter clears on entry to POLL.
- Latency: a request accepted at edge N into an empty idle block drives ym_cs_n low starting at edge N+2.
  - With busy never asserting, a full transaction lasts 2*STROBE_CYC + 2*GAP_CYC + 1 cycles from first strobe to return to IDLE, which is 17 cycles with defaults.
  - Back-to-back FIFO entries: the next A_STB begins 1 cycle after returning to IDLE.
- Hold: ym_addr and ym_din are held at their last values in IDLE (not zeroed).
- timeout_err:
  - clr_err clears it on the next edge.
  - If clr_err and a new timeout occur in the same cycle, set wins.
- idle = (fifo_count==0) && (FSM==IDLE), registered.

Test Plan:
- Single write: push reg=0x27, data=0x15; ym_dout=0x00 throughout -> cs_n low cycles 2-5 with addr=0, din=0x27; cs_n high cycles 6-9; cs_n low cycles 10-13 with addr=1, din=0x15; idle=1 at cycle 19.
- Busy handling: ym_dout[7]=1 for 30 cycles after the data strobe -> block stays in POLL, no new strobe until the cycle after busy drops, timeout_err stays 0.
- Timeout: ym_dout[7] stuck at 1 -> timeout_err=1 exactly 1023 POLL cycles after entry; next queued write then proceeds; clr_err -> timeout_err=0 next cycle.
- FIFO full: push 17 requests back-to-back while busy is stuck high -> req_ready low after 16 entries are held (count peaks at 16); all 16 accepted pairs are later replayed in order with matching reg/data.
- Simultaneous push/pop: push on the cycle IDLE pops with count=1 -> count stays 1.
- Reset mid-D_STB: assert rst for 1 cycle -> cs_n=1, wr_n=1, count=0, idle=1 on the following cycle; no further strobes.
